// File: rtl/tdes_pkg.sv
// Shared types and per-pass schedule constants for the Triple DES pass sequencer.
package tdes_pkg;

  localparam int TDES_BLOCK_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    PASS2 = 3'd2,
    PASS3 = 3'd3,
    DONE  = 3'd4
  } tdes_seq_state_t;

  // Entry [p] is pass p+1: key index (1..3) and direction (1 = DES decrypt).
  localparam logic [2:0][1:0] ENC_KEY_IDX = {2'd3, 2'd2, 2'd1};
  localparam logic [2:0][1:0] DEC_KEY_IDX = {2'd1, 2'd2, 2'd3};
  localparam logic [2:0]      ENC_DIR     = 3'b010;
  localparam logic [2:0]      DEC_DIR     = 3'b101;

  function automatic logic [1:0] pass_idx(tdes_seq_state_t s);
    case (s)
      PASS2:   return 2'd1;
      PASS3:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tdes_key_parity_check.sv
// Combinational odd-parity check over every byte of the three DES keys.
module tdes_key_parity_check
  import tdes_pkg::*;
(
  input  logic [TDES_BLOCK_W-1:0] key1,
  input  logic [TDES_BLOCK_W-1:0] key2,
  input  logic [TDES_BLOCK_W-1:0] key3,
  output logic                    fail
);

  logic [2:0][TDES_BLOCK_W-1:0] keys;
  assign keys = {key3, key2, key1};

  always_comb begin
    fail = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < TDES_BLOCK_W/8; b++)
        fail = fail | ~(^keys[k][8*b +: 8]);
  end

endmodule

// File: rtl/tdes_pass_sequencer.sv
// Runs one shared DES core through the three EDE/DED passes of Triple DES.
// Optional key parity check enabled by defining TDES_KEY_PARITY_CHECK_EN.
module tdes_pass_sequencer
  import tdes_pkg::*;
(
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    enable,
  input  logic                    encryptionType,
  input  logic [TDES_BLOCK_W-1:0] data,
  input  logic [TDES_BLOCK_W-1:0] key1,
  input  logic [TDES_BLOCK_W-1:0] key2,
  input  logic [TDES_BLOCK_W-1:0] key3,
  output logic                    des_start,
  output logic                    des_decrypt,
  output logic [TDES_BLOCK_W-1:0] des_key,
  output logic [TDES_BLOCK_W-1:0] des_data_in,
  input  logic                    des_done,
  input  logic [TDES_BLOCK_W-1:0] des_data_out,
  output logic                    busy,
  output logic                    outputEnable,
  output logic [TDES_BLOCK_W-1:0] outputData
`ifdef TDES_KEY_PARITY_CHECK_EN
  ,
  output logic                    key_error
`endif
);

  tdes_seq_state_t state_q, state_d;
  logic                    start_q, start_d;
  logic                    type_q, type_d;
  logic                    oe_q, oe_d;
  logic [TDES_BLOCK_W-1:0] data_q, data_d;
  logic [TDES_BLOCK_W-1:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
  logic [TDES_BLOCK_W-1:0] mid_q, mid_d;
  logic [TDES_BLOCK_W-1:0] out_q, out_d;
  logic                    done_acc, in_pass;
  logic [1:0]              pidx, kidx;

`ifdef TDES_KEY_PARITY_CHECK_EN
  logic kerr_q, kerr_d, parity_fail;

  tdes_key_parity_check u_parity (
    .key1 (key1),
    .key2 (key2),
    .key3 (key3),
    .fail (parity_fail)
  );
`endif

  // The core may still show a stale done in the launch cycle; only later strobes count.
  assign done_acc = des_done & ~start_q;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    type_d  = type_q;
    data_d  = data_q;
    key1_d  = key1_q;
    key2_d  = key2_q;
    key3_d  = key3_q;
    mid_d   = mid_q;
    out_d   = out_q;
    oe_d    = oe_q;
`ifdef TDES_KEY_PARITY_CHECK_EN
    kerr_d  = kerr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          type_d = encryptionType;
          data_d = data;
          key1_d = key1;
          key2_d = key2;
          key3_d = key3;
          oe_d   = 1'b0;
`ifdef TDES_KEY_PARITY_CHECK_EN
          kerr_d = 1'b0;
          if (parity_fail) begin
            state_d = DONE;
            oe_d    = 1'b1;
            out_d   = '0;
            kerr_d  = 1'b1;
          end else begin
            state_d = PASS1;
            start_d = 1'b1;
          end
`else
          state_d = PASS1;
          start_d = 1'b1;
`endif
        end
      end
      PASS1, PASS2: begin
        if (done_acc) begin
          mid_d   = des_data_out;
          state_d = (state_q == PASS1) ? PASS2 : PASS3;
          start_d = 1'b1;
        end
      end
      PASS3: begin
        if (done_acc) begin
          out_d   = des_data_out;
          oe_d    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      type_q  <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= '0;
      key1_q  <= '0;
      key2_q  <= '0;
      key3_q  <= '0;
      mid_q   <= '0;
      out_q   <= '0;
`ifdef TDES_KEY_PARITY_CHECK_EN
      kerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      type_q  <= type_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      key1_q  <= key1_d;
      key2_q  <= key2_d;
      key3_q  <= key3_d;
      mid_q   <= mid_d;
      out_q   <= out_d;
`ifdef TDES_KEY_PARITY_CHECK_EN
      kerr_q  <= kerr_d;
`endif
    end
  end

  // Core-facing controls decode from registered state and latched inputs only.
  assign in_pass = (state_q == PASS1) | (state_q == PASS2) | (state_q == PASS3);
  assign pidx    = pass_idx(state_q);
  assign kidx    = type_q ? ENC_KEY_IDX[pidx] : DEC_KEY_IDX[pidx];

  always_comb begin
    des_key = '0;
    if (in_pass) begin
      case (kidx)
        2'd1:    des_key = key1_q;
        2'd2:    des_key = key2_q;
        default: des_key = key3_q;
      endcase
    end
  end

  assign des_decrypt  = in_pass & (type_q ? ENC_DIR[pidx] : DEC_DIR[pidx]);
  assign des_data_in  = !in_pass ? '0 : (state_q == PASS1) ? data_q : mid_q;
  assign des_start    = start_q;
  assign busy         = in_pass;
  assign outputEnable = oe_q;
  assign outputData   = out_q;
`ifdef TDES_KEY_PARITY_CHECK_EN
  assign key_error    = kerr_q;
`endif

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Directed bench for tdes_pass_sequencer with an XOR mock DES core answering 4 cycles after des_start.
module tb_tdes_pass_sequencer;

  localparam int N = 4;
  localparam logic [63:0] DATA = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1   = 64'h0101010101010101;
  localparam logic [63:0] K2   = 64'h0202020202020202;
  localparam logic [63:0] K3   = 64'h0404040404040404;
  localparam logic [63:0] EXP  = 64'h062442608EACCAE8;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        enable = 1'b0;
  logic        encryptionType = 1'b0;
  logic [63:0] data = DATA, key1 = K1, key2 = K2, key3 = K3;
  logic        des_start, des_decrypt, des_done, busy, outputEnable;
  logic [63:0] des_key, des_data_in, des_data_out, outputData;
`ifdef TDES_KEY_PARITY_CHECK_EN
  logic        key_error;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0;
  logic [63:0] log_key [8];
  logic        log_dec [8];

  always #5 HCLK = ~HCLK;

  tdes_pass_sequencer dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .enable         (enable),
    .encryptionType (encryptionType),
    .data           (data),
    .key1           (key1),
    .key2           (key2),
    .key3           (key3),
    .des_start      (des_start),
    .des_decrypt    (des_decrypt),
    .des_key        (des_key),
    .des_data_in    (des_data_in),
    .des_done       (des_done),
    .des_data_out   (des_data_out),
    .busy           (busy),
    .outputEnable   (outputEnable),
    .outputData     (outputData)
`ifdef TDES_KEY_PARITY_CHECK_EN
    ,
    .key_error      (key_error)
`endif
  );

  // Mock core: XOR result, done strobe N cycles after the launch cycle.
  logic pending;
  int   cnt;
  always @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      pending <= 1'b0;
      cnt     <= 0;
    end else if (des_start) begin
      pending <= 1'b1;
      cnt     <= 1;
    end else if (pending) begin
      if (cnt == N) pending <= 1'b0;
      else          cnt <= cnt + 1;
    end
  end
  assign des_done     = pending && (cnt == N);
  assign des_data_out = des_data_in ^ des_key;

  always @(negedge HCLK) begin
    if (des_start) begin
      if (n_starts < 8) begin
        log_key[n_starts] = des_key;
        log_dec[n_starts] = des_decrypt;
      end
      n_starts = n_starts + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; launches a run and follows it to outputEnable.
  task automatic run(input logic enc, input int pulse_cyc, input string tag,
                     input logic [63:0] ek0, input logic [63:0] ek1, input logic [63:0] ek2,
                     input logic [2:0] ed);
    int cyc;
    n_starts = 0;
    encryptionType = enc;
    enable = 1'b1;
    @(negedge HCLK);
    enable = 1'b0;
    cyc = 1;
    chk({tag, "_c1_start"}, 64'(des_start), 64'd1);
    chk({tag, "_c1_busy"}, 64'(busy), 64'd1);
    chk({tag, "_c1_oe"}, 64'(outputEnable), 64'd0);
    chk({tag, "_c1_din"}, des_data_in, DATA);
    while (!outputEnable && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
      enable = (cyc == pulse_cyc);
    end
    enable = 1'b0;
    chk({tag, "_oe_cycle"}, 64'(cyc), 64'd16);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, outputData, EXP);
    chk({tag, "_nstarts"}, 64'(n_starts), 64'd3);
    chk({tag, "_key0"}, log_key[0], ek0);
    chk({tag, "_key1"}, log_key[1], ek1);
    chk({tag, "_key2"}, log_key[2], ek2);
    chk({tag, "_dirs"}, {61'd0, log_dec[2], log_dec[1], log_dec[0]}, {61'd0, ed});
`ifdef TDES_KEY_PARITY_CHECK_EN
    chk({tag, "_kerr"}, 64'(key_error), 64'd0);
`endif
    repeat (2) @(negedge HCLK);
    chk({tag, "_hold_oe"}, 64'(outputEnable), 64'd1);
    chk({tag, "_hold_data"}, outputData, EXP);
  endtask

  initial begin
    repeat (2) @(negedge HCLK);
    chk("rst_start", 64'(des_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_oe", 64'(outputEnable), 64'd0);
    chk("rst_key", des_key, 64'd0);
    chk("rst_din", des_data_in, 64'd0);
    chk("rst_out", outputData, 64'd0);
    HRESET = 1'b1;
    @(negedge HCLK);

    // Encrypt from IDLE, then decrypt started straight from DONE.
    run(1'b1, 0, "enc", K1, K2, K3, 3'b010);
    run(1'b0, 0, "dec_b2b", K3, K2, K1, 3'b101);

    // enable pulsed during PASS2 (cycles 6..10) must be ignored.
    run(1'b1, 7, "enable_in_pass2", K1, K2, K3, 3'b010);

    // Reset in PASS2.
    n_starts = 0;
    encryptionType = 1'b1;
    enable = 1'b1;
    @(negedge HCLK);
    enable = 1'b0;
    repeat (6) @(negedge HCLK);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    HRESET = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_start", 64'(des_start), 64'd0);
    chk("midrst_dec", 64'(des_decrypt), 64'd0);
    chk("midrst_key", des_key, 64'd0);
    chk("midrst_din", des_data_in, 64'd0);
    chk("midrst_oe", 64'(outputEnable), 64'd0);
    chk("midrst_out", outputData, 64'd0);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    run(1'b1, 0, "after_rst", K1, K2, K3, 3'b010);

`ifdef TDES_KEY_PARITY_CHECK_EN
    key2 = 64'h0303030303030303;
    n_starts = 0;
    enable = 1'b1;
    @(negedge HCLK);
    enable = 1'b0;
    chk("par_kerr", 64'(key_error), 64'd1);
    chk("par_oe", 64'(outputEnable), 64'd1);
    chk("par_out", outputData, 64'd0);
    chk("par_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge HCLK);
    chk("par_nstarts", 64'(n_starts), 64'd0);
    chk("par_kerr_hold", 64'(key_error), 64'd1);
    key2 = K2;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
